// File: rtl/fft_pitch_pkg.sv
// Shared types and constants for the FFT pitch scheduler.
package fft_pitch_pkg;

   // Controller sequencing states
   typedef enum logic [2:0] {
      WAIT_FRAME = 3'd0,
      START      = 3'd1,
      RUN        = 3'd2,
      SCAN       = 3'd3,
      REPORT     = 3'd4
   } fsm_state_t;

   // Default frame length and the bin index type it implies
   localparam int DEFAULT_NSAMPLES = 256;
   typedef logic [$clog2(DEFAULT_NSAMPLES)-1:0] bin_idx_t;

   // Reported bin value meaning "no pitch detected"
   localparam int NO_PITCH = 0;

endpackage

// File: rtl/frame_fill_ctrl.sv
// Frame fill side: decimation, ping-pong bank/address generation and the
// handoff-or-drop decision at the end of each frame.
module frame_fill_ctrl #(
   parameter int NSamples = 256,
   parameter int W        = 16,
   parameter int DECIM    = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [W-1:0]                sample_data,
   input  logic                        sample_valid,
   input  logic                        accept_frame,
   output logic                        buf_wr_en,
   output logic                        buf_wr_bank,
   output logic [$clog2(NSamples)-1:0] buf_wr_addr,
   output logic [W-1:0]                buf_wr_data,
   output logic                        handoff,
   output logic                        handoff_bank,
   output logic [7:0]                  overrun_count
);

   localparam int AW  = $clog2(NSamples);
   localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [DCW-1:0] dec_cnt;
   logic [AW-1:0]  fill_addr;
   logic           fill_bank;

   // Accept samples, keep one in DECIM, write it and close frames; a frame
   // that completes while the controller is busy is dropped and its bank
   // is refilled, so the bank under FFT is never overwritten.
   always_ff @(posedge clk) begin
      if (reset) begin
         dec_cnt       <= '0;
         fill_addr     <= '0;
         fill_bank     <= 1'b0;
         buf_wr_en     <= 1'b0;
         buf_wr_bank   <= 1'b0;
         buf_wr_addr   <= '0;
         buf_wr_data   <= '0;
         handoff       <= 1'b0;
         handoff_bank  <= 1'b0;
         overrun_count <= 8'd0;
      end else begin
         buf_wr_en <= 1'b0;
         handoff   <= 1'b0;
         if (!enable) begin
            dec_cnt   <= '0;
            fill_addr <= '0;
         end else if (sample_valid) begin
            dec_cnt <= (dec_cnt == DCW'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
            if (dec_cnt == '0) begin
               buf_wr_en   <= 1'b1;
               buf_wr_bank <= fill_bank;
               buf_wr_addr <= fill_addr;
               buf_wr_data <= sample_data;
               if (fill_addr == AW'(NSamples - 1)) begin
                  fill_addr <= '0;
                  if (accept_frame) begin
                     handoff      <= 1'b1;
                     handoff_bank <= fill_bank;
                     fill_bank    <= ~fill_bank;
                  end else if (overrun_count != 8'hFF) begin
                     overrun_count <= overrun_count + 8'd1;
                  end
               end else begin
                  fill_addr <= fill_addr + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/fft_frame_scheduler.sv
// FFT pitch controller: fills ping-pong frames, starts the FFT on each
// completed bank, scans the magnitude stream for the peak bin and reports it.
// Optional build macro: PITCH_THRESHOLD_EN adds mag_threshold; peaks below
// it are reported as NO_PITCH.
module fft_frame_scheduler #(
   parameter int NSamples = 256,
   parameter int W        = 16,
   parameter int MW       = 32,
   parameter int DECIM    = 4,
   parameter int MIN_BIN  = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [W-1:0]                sample_data,
   input  logic                        sample_valid,
   output logic                        buf_wr_en,
   output logic                        buf_wr_bank,
   output logic [$clog2(NSamples)-1:0] buf_wr_addr,
   output logic [W-1:0]                buf_wr_data,
   output logic                        fft_start,
   output logic                        fft_bank,
   input  logic                        fft_done,
   input  logic                        mag_valid,
   input  logic [$clog2(NSamples)-1:0] mag_index,
   input  logic [MW-1:0]               mag_data,
   input  logic                        mag_last,
`ifdef PITCH_THRESHOLD_EN
   input  logic [MW-1:0]               mag_threshold,
`endif
   output logic [$clog2(NSamples)-1:0] pitch_output_data,
   output logic                        pitch_output_valid,
   output logic [7:0]                  overrun_count,
   output logic                        busy
);

   import fft_pitch_pkg::*;

   localparam int AW = $clog2(NSamples);

   // Handshakes: sample_valid is always accepted (no ready); fft_start and
   // fft_done are single-cycle pulses; a magnitude beat is consumed in any
   // SCAN cycle where mag_valid is high, and mag_last closes the stream.

   fsm_state_t     state;
   logic [MW-1:0]  peak_mag;
   logic [AW-1:0]  peak_idx;
   logic           handoff;
   logic           handoff_bank;
   logic           in_range;
   logic           below_threshold;

   frame_fill_ctrl #(
      .NSamples (NSamples),
      .W        (W),
      .DECIM    (DECIM)
   ) u_fill (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .sample_data   (sample_data),
      .sample_valid  (sample_valid),
      .accept_frame  (state == WAIT_FRAME),
      .buf_wr_en     (buf_wr_en),
      .buf_wr_bank   (buf_wr_bank),
      .buf_wr_addr   (buf_wr_addr),
      .buf_wr_data   (buf_wr_data),
      .handoff       (handoff),
      .handoff_bank  (handoff_bank),
      .overrun_count (overrun_count)
   );

   // Only bins from MIN_BIN up to (not including) Nyquist may win
   assign in_range = (mag_index >= AW'(MIN_BIN)) && (mag_index < AW'(NSamples / 2));

`ifdef PITCH_THRESHOLD_EN
   assign below_threshold = (peak_mag < mag_threshold);
`else
   assign below_threshold = 1'b0;
`endif

   assign busy = (state != WAIT_FRAME);

   // Sequencer: handoff -> start pulse -> wait done -> peak scan -> report
   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= WAIT_FRAME;
         fft_start          <= 1'b0;
         fft_bank           <= 1'b0;
         pitch_output_data  <= '0;
         pitch_output_valid <= 1'b0;
         peak_mag           <= '0;
         peak_idx           <= '0;
      end else begin
         fft_start          <= 1'b0;
         pitch_output_valid <= 1'b0;
         case (state)
            WAIT_FRAME: begin
               if (handoff) begin
                  fft_bank <= handoff_bank;
                  state    <= START;
               end
            end
            START: begin
               fft_start <= 1'b1;
               peak_mag  <= '0;
               peak_idx  <= AW'(MIN_BIN);
               state     <= RUN;
            end
            RUN: begin
               if (fft_done) state <= SCAN;
            end
            SCAN: begin
               if (mag_valid) begin
                  // Strict compare keeps the lowest index on ties
                  if (in_range && (mag_data > peak_mag)) begin
                     peak_mag <= mag_data;
                     peak_idx <= mag_index;
                  end
                  if (mag_last) state <= REPORT;
               end
            end
            REPORT: begin
               pitch_output_valid <= 1'b1;
               pitch_output_data  <= below_threshold ? AW'(NO_PITCH) : peak_idx;
               state              <= WAIT_FRAME;
            end
            default: state <= WAIT_FRAME;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed testbench for fft_frame_scheduler (NSamples=256, DECIM=4).
module tb_fft_frame_scheduler;

   localparam int NS   = 256;
   localparam int W    = 16;
   localparam int MW   = 32;
   localparam int AW   = 8;
   localparam int WR_W = 1 + AW + W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          reset, enable, sample_valid;
   logic [W-1:0]  sample_data;
   logic          buf_wr_en, buf_wr_bank;
   logic [AW-1:0] buf_wr_addr;
   logic [W-1:0]  buf_wr_data;
   logic          fft_start, fft_bank, fft_done;
   logic          mag_valid, mag_last;
   logic [AW-1:0] mag_index;
   logic [MW-1:0] mag_data;
   logic [AW-1:0] pitch_output_data;
   logic          pitch_output_valid;
   logic [7:0]    overrun_count;
   logic          busy;
`ifdef PITCH_THRESHOLD_EN
   logic [MW-1:0] mag_threshold;
`endif

   fft_frame_scheduler #(
      .NSamples (NS), .W (W), .MW (MW), .DECIM (4), .MIN_BIN (2)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .enable             (enable),
      .sample_data        (sample_data),
      .sample_valid       (sample_valid),
      .buf_wr_en          (buf_wr_en),
      .buf_wr_bank        (buf_wr_bank),
      .buf_wr_addr        (buf_wr_addr),
      .buf_wr_data        (buf_wr_data),
      .fft_start          (fft_start),
      .fft_bank           (fft_bank),
      .fft_done           (fft_done),
      .mag_valid          (mag_valid),
      .mag_index          (mag_index),
      .mag_data           (mag_data),
      .mag_last           (mag_last),
`ifdef PITCH_THRESHOLD_EN
      .mag_threshold      (mag_threshold),
`endif
      .pitch_output_data  (pitch_output_data),
      .pitch_output_valid (pitch_output_valid),
      .overrun_count      (overrun_count),
      .busy               (busy)
   );

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   int sdata = 0;

   logic [WR_W-1:0] exp_q[$];
   logic [WR_W-1:0] wr_q[$];
   int              wr_cyc_q[$];
   int              st_cyc_q[$];
   logic            st_bank_q[$];
   int              pv_cyc_q[$];
   logic [AW-1:0]   pv_data_q[$];

   // Monitor: log DUT events on the falling edge
   always @(negedge clk) begin
      if (buf_wr_en) begin
         wr_q.push_back({buf_wr_bank, buf_wr_addr, buf_wr_data});
         wr_cyc_q.push_back(cyc);
      end
      if (fft_start) begin
         st_cyc_q.push_back(cyc);
         st_bank_q.push_back(fft_bank);
      end
      if (pitch_output_valid) begin
         pv_cyc_q.push_back(cyc);
         pv_data_q.push_back(pitch_output_data);
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      exp_q.delete(); wr_q.delete(); wr_cyc_q.delete();
      st_cyc_q.delete(); st_bank_q.delete();
      pv_cyc_q.delete(); pv_data_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
      fft_done = 1'b0; mag_valid = 1'b0; mag_last = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   function automatic logic [MW-1:0] pat_val(input int p, input int i);
      case (p)
         0:       return (i == 40) ? 32'd1000 : 32'd10;
         1:       return (i == 1) ? 32'd5000 : (i == 200) ? 32'd9000 : (i == 3) ? 32'd50 : 32'd0;
         2:       return (i == 10 || i == 20) ? 32'd777 : 32'd5;
         default: return 32'd0;
      endcase
   endfunction

   // Stream samples until the next fft_start, then check the bank handed off
   task automatic fill_until_start(input logic exp_bank, input string name);
      int n0;
      int guard;
      n0 = st_cyc_q.size();
      guard = 0;
      enable = 1'b1;
      while (st_cyc_q.size() == n0 && guard < 1200) begin
         @(posedge clk); #1;
         sample_valid = 1'b1;
         sample_data  = W'(sdata);
         sdata++;
         guard++;
      end
      sample_valid = 1'b0;
      n_cmp++;
      if (st_cyc_q.size() == n0) begin
         n_err++;
         $display("FAIL %s_start: no fft_start within %0d cycles", name, guard);
      end
      n_cmp++;
      if (fft_bank !== exp_bank) begin
         n_err++;
         $display("FAIL %s_bank: fft_bank=%0b expected %0b", name, fft_bank, exp_bank);
      end
   endtask

   // Deliver fft_done and a full magnitude stream, then check the report
   task automatic run_fft(input int p, input int exp_pitch, input bit stray, input string name);
      int last_cyc;
      last_cyc = 0;
      pv_cyc_q.delete(); pv_data_q.delete();
      if (stray) begin
         // A beat while still waiting for fft_done must be ignored
         @(posedge clk); #1;
         mag_valid = 1'b1; mag_index = 8'd50; mag_data = 32'hFFFF_FFFF; mag_last = 1'b1;
         @(posedge clk); #1;
         mag_valid = 1'b0; mag_last = 1'b0;
      end
      @(posedge clk); #1 fft_done = 1'b1;
      @(posedge clk); #1 fft_done = 1'b0;
      for (int i = 0; i < NS; i++) begin
         mag_valid = 1'b1;
         mag_index = AW'(i);
         mag_data  = pat_val(p, i);
         mag_last  = (i == NS - 1);
         if (i == NS - 1) last_cyc = cyc;
         @(posedge clk); #1;
      end
      mag_valid = 1'b0; mag_last = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (pv_cyc_q.size() != 1) begin
         n_err++;
         $display("FAIL %s_valid_count: %0d strobes expected 1", name, pv_cyc_q.size());
      end else begin
         n_cmp++;
         if (pv_data_q[0] !== AW'(exp_pitch)) begin
            n_err++;
            $display("FAIL %s_pitch: got %0d expected %0d", name, pv_data_q[0], exp_pitch);
         end
         n_cmp++;
         if (pv_cyc_q[0] !== last_cyc + 2) begin
            n_err++;
            $display("FAIL %s_latency: valid at cycle %0d expected %0d", name, pv_cyc_q[0], last_cyc + 2);
         end
      end
      n_cmp++;
      if (pitch_output_data !== AW'(exp_pitch)) begin
         n_err++;
         $display("FAIL %s_hold: pitch_output_data=%0d expected %0d", name, pitch_output_data, exp_pitch);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({buf_wr_en, buf_wr_bank, buf_wr_addr, buf_wr_data, fft_start, fft_bank,
           pitch_output_data, pitch_output_valid, overrun_count, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: wr_en=%b bank=%b addr=%h data=%h start=%b fbank=%b pitch=%h pv=%b ovr=%h busy=%b expected all 0",
                  buf_wr_en, buf_wr_bank, buf_wr_addr, buf_wr_data, fft_start, fft_bank,
                  pitch_output_data, pitch_output_valid, overrun_count, busy);
      end
      reset = 1'b0;
      clear_logs();
      // fft_done and a final mag beat while idle must not move the FSM
      @(posedge clk); #1 fft_done = 1'b1; mag_valid = 1'b1; mag_last = 1'b1; mag_index = 8'd9; mag_data = 32'd7;
      @(posedge clk); #1 fft_done = 1'b0; mag_valid = 1'b0; mag_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0 || st_cyc_q.size() != 0 || pv_cyc_q.size() != 0) begin
         n_err++;
         $display("FAIL idle_ignore: busy=%b starts=%0d reports=%0d expected 0/0/0",
                  busy, st_cyc_q.size(), pv_cyc_q.size());
      end
   endtask

   task automatic test_first_frame();
      int n;
      clear_logs();
      enable = 1'b1;
      for (int k = 0; k < 1032; k++) begin
         @(posedge clk); #1;
         sample_valid = 1'b1;
         sample_data  = W'(k);
         if (k % 4 == 0) exp_q.push_back({(k >= 1024), AW'((k / 4) % NS), W'(k)});
      end
      @(posedge clk); #1 sample_valid = 1'b0;
      sdata = 1032;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (wr_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL first_frame_write_count: got %0d expected %0d", wr_q.size(), exp_q.size());
      end
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (wr_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL first_frame_write[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]);
            break;
         end
      end
      n_cmp++;
      if (st_cyc_q.size() != 1 || wr_cyc_q.size() < 256) begin
         n_err++;
         $display("FAIL first_frame_start_count: starts=%0d writes=%0d expected 1 and >=256",
                  st_cyc_q.size(), wr_cyc_q.size());
      end else begin
         n_cmp++;
         if (st_cyc_q[0] !== wr_cyc_q[255] + 2) begin
            n_err++;
            $display("FAIL first_frame_start_latency: start at %0d expected %0d", st_cyc_q[0], wr_cyc_q[255] + 2);
         end
         n_cmp++;
         if (st_bank_q[0] !== 1'b0) begin
            n_err++;
            $display("FAIL first_frame_start_bank: got %0b expected 0", st_bank_q[0]);
         end
      end
   endtask

   task automatic test_reset_in_scan();
      pv_cyc_q.delete(); pv_data_q.delete();
      @(posedge clk); #1 fft_done = 1'b1;
      @(posedge clk); #1 fft_done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         mag_valid = 1'b1; mag_index = AW'(i); mag_data = pat_val(0, i); mag_last = 1'b0;
         @(posedge clk); #1;
      end
      mag_valid = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL scan_busy: busy=%b expected 1", busy);
      end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      n_cmp++;
      if ({fft_bank, pitch_output_data, busy, pitch_output_valid, fft_start, buf_wr_en, overrun_count} !== '0) begin
         n_err++;
         $display("FAIL scan_reset_outputs: fbank=%b pitch=%0d busy=%b pv=%b start=%b wr_en=%b ovr=%0d expected all 0",
                  fft_bank, pitch_output_data, busy, pitch_output_valid, fft_start, buf_wr_en, overrun_count);
      end
      for (int i = 100; i < NS; i++) begin
         mag_valid = 1'b1; mag_index = AW'(i); mag_data = pat_val(0, i); mag_last = (i == NS - 1);
         @(posedge clk); #1;
      end
      mag_valid = 1'b0; mag_last = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (pv_cyc_q.size() != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL scan_reset_no_report: reports=%0d busy=%b expected 0/0", pv_cyc_q.size(), busy);
      end
   endtask

   task automatic test_overrun();
      int n;
      int bank0_writes;
      do_reset();
      clear_logs();
      enable = 1'b1;
      for (int k = 0; k < 1024; k++) begin
         @(posedge clk); #1 sample_valid = 1'b1; sample_data = W'(k);
      end
      wr_q.delete(); wr_cyc_q.delete();
      for (int k = 1024; k < 2056; k++) begin
         @(posedge clk); #1 sample_valid = 1'b1; sample_data = W'(k);
         if (k % 4 == 0) exp_q.push_back({1'b1, AW'(((k - 1024) / 4) % NS), W'(k)});
      end
      @(posedge clk); #1 sample_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (overrun_count !== 8'd1) begin
         n_err++;
         $display("FAIL overrun_count: got %0d expected 1", overrun_count);
      end
      n_cmp++;
      if (fft_bank !== 1'b0 || st_cyc_q.size() != 1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_fft_side: fft_bank=%b starts=%0d busy=%b expected 0/1/1",
                  fft_bank, st_cyc_q.size(), busy);
      end
      bank0_writes = 0;
      foreach (wr_q[i]) if (wr_q[i][WR_W-1] == 1'b0) bank0_writes++;
      n_cmp++;
      if (bank0_writes != 0) begin
         n_err++;
         $display("FAIL overrun_bank0_writes: got %0d expected 0", bank0_writes);
      end
      n_cmp++;
      if (wr_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL overrun_write_count: got %0d expected %0d", wr_q.size(), exp_q.size());
      end
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (wr_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL overrun_write[%0d]: got %h expected %h", i, wr_q[i], exp_q[i]);
            break;
         end
      end
   endtask

   task automatic test_enable_drop();
      do_reset();
      clear_logs();
      enable = 1'b1;
      for (int k = 0; k <= 400; k++) begin
         @(posedge clk); #1 sample_valid = 1'b1; sample_data = W'(k);
      end
      @(posedge clk); #1 enable = 1'b0; sample_data = 16'hDEAD;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (wr_q.size() != 101 || wr_q[wr_q.size() - 1] !== {1'b0, 8'd100, 16'd400}) begin
         n_err++;
         $display("FAIL enable_partial: writes=%0d expected 101 ending at addr 100", wr_q.size());
      end
      clear_logs();
      enable = 1'b1;
      for (int k = 0; k < 1024; k++) begin
         sample_valid = 1'b1; sample_data = W'(5000 + k);
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (wr_q.size() != 256) begin
         n_err++;
         $display("FAIL enable_refill_count: got %0d expected 256", wr_q.size());
      end else begin
         n_cmp++;
         if (wr_q[0] !== {1'b0, 8'd0, 16'd5000}) begin
            n_err++;
            $display("FAIL enable_first_write: got %h expected %h", wr_q[0], {1'b0, 8'd0, 16'd5000});
         end
         n_cmp++;
         if (wr_q[255] !== {1'b0, 8'd255, 16'd6020}) begin
            n_err++;
            $display("FAIL enable_last_write: got %h expected %h", wr_q[255], {1'b0, 8'd255, 16'd6020});
         end
         n_cmp++;
         if (st_cyc_q.size() != 1 || st_cyc_q[0] !== wr_cyc_q[255] + 2) begin
            n_err++;
            $display("FAIL enable_start: starts=%0d first at %0d expected 1 at %0d",
                     st_cyc_q.size(), (st_cyc_q.size() > 0) ? st_cyc_q[0] : -1, wr_cyc_q[255] + 2);
         end
      end
   endtask

`ifdef PITCH_THRESHOLD_EN
   task automatic test_threshold();
      do_reset();
      mag_threshold = 32'd2000;
      fill_until_start(1'b0, "threshold_fill");
      run_fft(0, 0, 1'b0, "threshold_low_peak");
      mag_threshold = 32'd0;
   endtask
`endif

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0;
      fft_done = 1'b0; mag_valid = 1'b0; mag_index = '0; mag_data = '0; mag_last = 1'b0;
`ifdef PITCH_THRESHOLD_EN
      mag_threshold = 32'd0;
`endif
      test_reset();
      test_first_frame();
      run_fft(0, 40, 1'b0, "peak_basic");
      fill_until_start(1'b1, "fill_b1");
      run_fft(1, 3, 1'b0, "peak_range");
      fill_until_start(1'b0, "fill_b0");
      run_fft(2, 10, 1'b1, "peak_tie");
      fill_until_start(1'b1, "fill_b1_again");
      test_reset_in_scan();
      fill_until_start(1'b0, "fill_after_reset");
      run_fft(3, 2, 1'b0, "zero_spectrum");
      test_overrun();
      test_enable_drop();
`ifdef PITCH_THRESHOLD_EN
      test_threshold();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Single-clock controller that sequences the FFT pitch datapath.
- Decimates the incoming audio sample stream and fills a ping-pong frame buffer (two banks of NSamples).
- When a frame is complete, issues an FFT start on that bank, waits for completion, then scans the returned magnitude stream for the peak bin and reports it as the pitch.
- Sits between the audio CDC FIFO output and the FFT core / frame RAM, all in the fft_clk domain.

Parameters:
- NSamples, 256, frame length and FFT size; power of two, 16..4096
- W, 16, audio sample width
- MW, 32, magnitude width returned by FFT core
- DECIM, 4, keep 1 of every DECIM accepted samples (48 kHz -> 12 kHz); 1 = no decimation
- MIN_BIN, 2, lowest bin eligible as peak (rejects DC and near-DC)

Ports:
- clk  in  1  FFT-domain clock
- reset  in  1  synchronous, active-high
- enable  in  1  frame collection enable
- sample_data  in  W  audio sample
- sample_valid  in  1  sample strobe; always accepted, no backpressure
- buf_wr_en  out  1  frame RAM write strobe
- buf_wr_bank  out  1  bank being written
- buf_wr_addr  out  $clog2(NSamples)  write address
- buf_wr_data  out  W  write data
- fft_start  out  1  one-cycle start pulse
- fft_bank  out  1  bank the FFT must read; held stable from fft_start until fft_done
- fft_done  in  1  one-cycle FFT completion pulse
- mag_valid  in  1  magnitude beat valid
- mag_index  in  $clog2(NSamples)  bin index of the beat
- mag_data  in  MW  unsigned magnitude
- mag_last  in  1  final beat of the magnitude stream
- pitch_output_data  out  $clog2(NSamples)  peak bin
- pitch_output_valid  out  1  one-cycle result strobe
- overrun_count  out  8  dropped frames, saturating
- busy  out  1  FSM not in WAIT_FRAME

Behaviour:
- Reset values:
  - All outputs 0; fill bank = 0, fill address = 0, decimation count = 0.
  - FSM in WAIT_FRAME.
- Fill side:
  - When enable && sample_valid, the decimation counter advances 0..DECIM-1, then wraps.
  - A sample is kept when the counter == 0.
  - For a kept sample, buf_wr_* are registered, so the write appears 1 cycle after acceptance. The address then increments.
- Frame complete:
  - A frame completes when address NSamples-1 is written.
  - If the FSM is in WAIT_FRAME in that same cycle:
    - The completed bank is handed off (fft_bank <= fill bank).
    - The fill bank toggles and the address wraps to 0.
  - Otherwise the frame is dropped:
    - The fill bank is unchanged and the address wraps to 0, so the same bank is refilled.
    - overrun_count increments, saturating at 255.
  - The bank under FFT is therefore never written.
- enable low:
  - Fill address and decimation counter clear to 0 on the next cycle; the partial frame is discarded.
  - The FSM completes any frame already in progress.
- FSM:
  - WAIT_FRAME -> START on handoff.
  - START: fft_start=1 for exactly one cycle, then -> RUN.
  - RUN: wait for fft_done, then -> SCAN. Clear peak_mag=0 and peak_idx=MIN_BIN on entry.
  - SCAN:
    - On each mag_valid beat with MIN_BIN <= mag_index < NSamples/2 and mag_data > peak_mag (strict), update peak_mag/peak_idx. Ties keep the lower index.
    - Beats outside that range are ignored.
    - A beat with mag_valid && mag_last is evaluated, then the FSM goes -> REPORT.
  - REPORT: pitch_output_valid=1 for one cycle with pitch_output_data=peak_idx, then -> WAIT_FRAME.
  - pitch_output_data holds its value between reports.
- Latency:
  - fft_start occurs 2 cycles after the final sample write.
  - pitch_output_valid occurs 2 cycles after the mag_last beat.
- Ignored inputs:
  - fft_done outside RUN is ignored.
  - mag_valid outside SCAN is ignored.
- All-zero spectrum: reports MIN_BIN.
- Reset mid-operation: everything returns to reset values next cycle; no fft_start or pitch_output_valid is generated for the aborted frame.

Optional Feature:
- PITCH_THRESHOLD_EN
- When defined:
  - Adds input port mag_threshold [MW-1:0].
  - In REPORT, if peak_mag < mag_threshold, pitch_output_data = 0 (meaning "no pitch"); pitch_output_valid still pulses.
- When undefined: no port; the peak is always reported.

Decomposition:
- Package fft_pitch_pkg holds:
  - the FSM state enum (WAIT_FRAME, START, RUN, SCAN, REPORT);
  - the bin index typedef sized by $clog2(NSamples);
  - the NO_PITCH constant (0).
- Natural sub-module: frame_fill_ctrl, covering the decimation counter, address/bank generation and the overrun decision. The top keeps the FSM and peak search.

Test Plan:
- Continuous valid, DECIM=4, NSamples=256, enable=1:
  - 1024 samples produce 256 writes to bank 0, addr 0..255.
  - fft_start 2 cycles after the addr 255 write, with fft_bank=0.
  - Subsequent writes go to bank 1.
- Model returns fft_done, then 256 mag beats with bin 40 = 1000 and all others 10:
  - pitch_output_data=40, one-cycle valid, 2 cycles after mag_last.
- Peak search edge cases:
  - Bin 1 = 5000 and bin 200 = 9000 (both out of range) with bin 3 = 50: reports 3.
  - Equal maxima at bins 10 and 20: reports 10.
- Hold fft_done off for 2 frame times: overrun_count=1, bank 1 refilled, fft_bank stays 0.
- enable dropped at addr 100, then re-raised: the next frame starts at addr 0 and fft_start fires only after a full 256 writes.
- Assert reset during SCAN: outputs 0 next cycle, no pitch_output_valid for that frame. With PITCH_THRESHOLD_EN, threshold 2000 and peak 1000: reports 0.
